// File: rtl/mult_pkg.sv
// Shared definitions for the multiplier sequencer: FSM state encoding and
// default parameter values.
package mult_pkg;

    localparam int DEF_WIDTH      = 8;
    localparam int DEF_FIFO_DEPTH = 4;
    localparam int DEF_TIMEOUT    = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        WAIT   = 2'd2,
        RESULT = 2'd3
    } state_t;

endpackage

// File: rtl/mult_seq_fifo.sv
// Operand-pair queue for the multiplier sequencer. Pointers carry one extra
// wrap bit so full and empty are told apart without a separate counter.
// A push while full and a pop while empty are ignored.
module mult_seq_fifo
    import mult_pkg::*;
#(
    parameter int DW    = 2 * DEF_WIDTH,
    parameter int DEPTH = DEF_FIFO_DEPTH
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [DW-1:0] wdata,
    input  logic          pop,
    output logic [DW-1:0] rdata,
    output logic          full,
    output logic          empty
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW:0]   wptr;
    logic [AW:0]   rptr;

    // Advance read/write pointers; reset discards every pending entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push && !full)
                wptr <= wptr + 1'b1;
            if (pop && !empty)
                rptr <= rptr + 1'b1;
        end
    end

    // Storage needs no reset: entries are only readable between push and pop.
    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wptr[AW-1:0]] <= wdata;
    end

    assign rdata = mem[rptr[AW-1:0]];
    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

endmodule

// File: rtl/mult_sequencer.sv
// Multiplier sequencer: queues operand pairs, issues them one at a time to an
// external multiplier, and presents each product on a result handshake.
// Optional macro MULT_SEQ_TIMEOUT_EN adds a WAIT-state watchdog that aborts a
// multiplication after TIMEOUT cycles and flags it with out_err.
//
// Handshakes (in_valid/in_ready and out_valid/out_ready): a transfer happens
// on a rising clk edge where both valid and ready are high. The source holds
// valid and its data stable until the transfer; ready may be asserted or
// withdrawn freely and never depends on valid. in_ready is simply "queue not
// full"; out_valid is high exactly while the FSM is in RESULT.
module mult_sequencer
    import mult_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    output logic               mul_start,
    output logic [WIDTH-1:0]   mul_a,
    output logic [WIDTH-1:0]   mul_b,
    input  logic [2*WIDTH-1:0] mul_product,
    input  logic               mul_done,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_product,
    output logic               out_err,
    output logic [1:0]         dbg_state
);

    state_t             state;
    logic               q_full;
    logic               q_empty;
    logic               q_pop;
    logic [2*WIDTH-1:0] q_rdata;

    // Only IDLE removes the head of the queue, so one multiplication is in
    // flight at a time and results leave in push order.
    assign q_pop     = (state == IDLE) && !q_empty;
    assign in_ready  = !q_full;
    assign dbg_state = state;

    mult_seq_fifo #(
        .DW    (2 * WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (in_valid && in_ready),
        .wdata ({in_a, in_b}),
        .pop   (q_pop),
        .rdata (q_rdata),
        .full  (q_full),
        .empty (q_empty)
    );

`ifdef MULT_SEQ_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] tmo_cnt;
    logic          tmo_hit;

    assign tmo_hit = (tmo_cnt == CW'(TIMEOUT - 1));

    // Watchdog: cleared while entering WAIT, counts each WAIT cycle without done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            tmo_cnt <= '0;
        else if (state == ISSUE)
            tmo_cnt <= '0;
        else if ((state == WAIT) && !mul_done)
            tmo_cnt <= tmo_cnt + 1'b1;
    end
`else
    // No watchdog in this build: WAIT lasts until mul_done, never an error.
    logic unused_timeout;
    assign unused_timeout = ^(32'(TIMEOUT));
    assign out_err        = 1'b0;
`endif

    // Sequencing FSM with registered multiplier and result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            mul_start   <= 1'b0;
            mul_a       <= '0;
            mul_b       <= '0;
            out_valid   <= 1'b0;
            out_product <= '0;
`ifdef MULT_SEQ_TIMEOUT_EN
            out_err     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (!q_empty) begin
                        {mul_a, mul_b} <= q_rdata;
                        mul_start      <= 1'b1;
                        state          <= ISSUE;
                    end
                end
                ISSUE: begin
                    mul_start <= 1'b0;
                    state     <= WAIT;
                end
                WAIT: begin
                    // A real completion wins over a watchdog expiry on the same edge.
                    if (mul_done) begin
                        out_product <= mul_product;
                        out_valid   <= 1'b1;
`ifdef MULT_SEQ_TIMEOUT_EN
                        out_err     <= 1'b0;
`endif
                        state       <= RESULT;
                    end
`ifdef MULT_SEQ_TIMEOUT_EN
                    else if (tmo_hit) begin
                        out_product <= '0;
                        out_err     <= 1'b1;
                        out_valid   <= 1'b1;
                        state       <= RESULT;
                    end
`endif
                end
                RESULT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    mul_start <= 1'b0;
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
